// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous-read memory.
// Optional build macro MEMARB_FIXED_PRIO_EN gives requester A strict priority over B.
module mem_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_adr,
  input  logic [DATA_W-1:0] a_dat_w,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_dat_r,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_adr,
  input  logic [DATA_W-1:0] b_dat_w,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_dat_r,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_dat_w,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dat_r
);

  logic grant_a;
  logic grant_b;
  logic pend_a_reg;
  logic pend_b_reg;

`ifdef MEMARB_FIXED_PRIO_EN
  always_comb begin
    grant_a = a_valid && !rst;
    grant_b = b_valid && !a_valid && !rst;
  end
`else
  // last_b_reg remembers who won most recently; a tie goes to the other side.
  logic last_b_reg;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        grant_a = last_b_reg;
        grant_b = !last_b_reg;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_reg <= 1'b1;
    end else if (grant_b) begin
      last_b_reg <= 1'b1;
    end else if (grant_a) begin
      last_b_reg <= 1'b0;
    end
  end
`endif

  always_comb begin
    mem_adr   = '0;
    mem_dat_w = '0;
    mem_we    = 1'b0;
    if (grant_a) begin
      mem_adr   = a_adr;
      mem_dat_w = a_dat_w;
      mem_we    = a_we;
    end else if (grant_b) begin
      mem_adr   = b_adr;
      mem_dat_w = b_dat_w;
      mem_we    = b_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_a_reg <= 1'b0;
      pend_b_reg <= 1'b0;
    end else begin
      pend_a_reg <= grant_a && !a_we;
      pend_b_reg <= grant_b && !b_we;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Gating with rst drops a response whose read was issued just before reset.
  assign a_rsp_valid = pend_a_reg && !rst;
  assign b_rsp_valid = pend_b_reg && !rst;
  assign a_dat_r     = mem_dat_r;
  assign b_dat_r     = mem_dat_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: external memory model, per-cycle reference model and directed tests.
module tb_mem_port_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_adr = '0, b_adr = '0;
  logic [DW-1:0] a_dat_w = '0, b_dat_w = '0;
  logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid, mem_we;
  logic [DW-1:0] a_dat_r, b_dat_r, mem_dat_w, mem_dat_r;
  logic [AW-1:0] mem_adr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_adr(a_adr), .a_dat_w(a_dat_w),
    .a_rsp_valid(a_rsp_valid), .a_dat_r(a_dat_r),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_adr(b_adr), .b_dat_w(b_dat_w),
    .b_rsp_valid(b_rsp_valid), .b_dat_r(b_dat_r),
    .mem_adr(mem_adr), .mem_dat_w(mem_dat_w), .mem_we(mem_we), .mem_dat_r(mem_dat_r)
  );

  // Single-port 16x8 memory, registered read.
  logic [DW-1:0] ram [16];
  logic [DW-1:0] ram_q;
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '0;
    ram_q = '0;
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_adr] <= mem_dat_w;
    ram_q <= ram[mem_adr];
  end
  assign mem_dat_r = ram_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration rules, shadow memory, expected responses.
  bit            m_a_wins_tie = 1'b1;
  bit            m_pend_a = 1'b0, m_pend_b = 1'b0;
  logic [DW-1:0] m_data_a = '0, m_data_b = '0;
  logic [DW-1:0] shadow [16];
  initial for (int i = 0; i < 16; i++) shadow[i] = '0;

  always @(negedge clk) begin
    bit            ga, gb;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    bit            e_we;
`ifdef MEMARB_FIXED_PRIO_EN
    ga = a_valid && !rst;
    gb = b_valid && !a_valid && !rst;
`else
    ga = !rst && a_valid && (!b_valid || m_a_wins_tie);
    gb = !rst && b_valid && (!a_valid || !m_a_wins_tie);
`endif
    e_adr = ga ? a_adr : (gb ? b_adr : '0);
    e_dat = ga ? a_dat_w : (gb ? b_dat_w : '0);
    e_we  = ga ? a_we : (gb ? b_we : 1'b0);
    chk("m_a_ready", a_ready, ga);
    chk("m_b_ready", b_ready, gb);
    chk("m_mem_we", mem_we, e_we);
    chk("m_mem_adr", mem_adr, e_adr);
    chk("m_mem_dat_w", mem_dat_w, e_dat);
    chk("m_a_rsp_valid", a_rsp_valid, m_pend_a && !rst);
    chk("m_b_rsp_valid", b_rsp_valid, m_pend_b && !rst);
    if (m_pend_a && !rst) chk("m_a_dat_r", a_dat_r, m_data_a);
    if (m_pend_b && !rst) chk("m_b_dat_r", b_dat_r, m_data_b);
    if (ga || gb)
      $display("t=%0t grant %s %s adr=%0h dat=%0h", $time, ga ? "A" : "B",
               e_we ? "wr" : "rd", e_adr, e_dat);
    if (rst) begin
      m_pend_a = 1'b0;
      m_pend_b = 1'b0;
      m_a_wins_tie = 1'b1;
    end else begin
      m_pend_a = ga && !e_we;
      m_pend_b = gb && !e_we;
      if (ga || gb) begin
        if (e_we) shadow[e_adr] = e_dat;
        else if (ga) m_data_a = shadow[e_adr];
        else m_data_b = shadow[e_adr];
        m_a_wins_tie = gb;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit v, input bit we, input int adr, input int dat);
    a_valid = v; a_we = we; a_adr = adr[AW-1:0]; a_dat_w = dat[DW-1:0];
  endtask

  task automatic drive_b(input bit v, input bit we, input int adr, input int dat);
    b_valid = v; b_we = we; b_adr = adr[AW-1:0]; b_dat_w = dat[DW-1:0];
  endtask

  task automatic idle();
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
  endtask

  initial begin
    int nb;
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    cyc(); cyc();
    rst = 1'b0;

    // A writes 3=5A, then reads it back.
    drive_a(1, 1, 3, 'h5A);
    @(negedge clk); chk("t1_wr_ready", a_ready, 1);
    cyc();
    drive_a(1, 0, 3, 0);
    @(negedge clk); chk("t1_rd_ready", a_ready, 1);
    cyc();
    idle();
    @(negedge clk);
    chk("t1_rsp_valid", a_rsp_valid, 1);
    chk("t1_dat_r", a_dat_r, 'h5A);
    chk("t1_b_rsp_valid", b_rsp_valid, 0);
    cyc();

    // Preload 1=11, 2=22, then reset so A wins the first tie.
    drive_a(1, 1, 1, 'h11); cyc();
    idle(); drive_b(1, 1, 2, 'h22); cyc();
    idle(); rst = 1'b1; cyc();
    rst = 1'b0;

    // Both reading continuously for 6 cycles.
    drive_a(1, 0, 1, 0);
    drive_b(1, 0, 2, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifndef MEMARB_FIXED_PRIO_EN
      chk("t2_a_ready", a_ready, (i % 2) == 0);
      chk("t2_b_ready", b_ready, (i % 2) == 1);
      if (i > 0 && (i % 2) == 1) chk("t2_a_dat_r", a_dat_r, 'h11);
      if (i > 0 && (i % 2) == 0) chk("t2_b_dat_r", b_dat_r, 'h22);
`endif
      cyc();
    end
    idle();
    @(negedge clk);
`ifndef MEMARB_FIXED_PRIO_EN
    chk("t2_last_b_rsp", b_rsp_valid, 1);
    chk("t2_last_b_dat", b_dat_r, 'h22);
`endif
    cyc();

    // B writes 7=C3, A reads 7 right after.
    drive_b(1, 1, 7, 'hC3);
    @(negedge clk); chk("t3_b_ready", b_ready, 1);
    cyc();
    idle(); drive_a(1, 0, 7, 0);
    @(negedge clk); chk("t3_a_ready", a_ready, 1);
    cyc();
    idle();
    @(negedge clk);
    chk("t3_rsp_valid", a_rsp_valid, 1);
    chk("t3_dat_r", a_dat_r, 'hC3);
    cyc();

    // Only B valid for 4 cycles: one access per cycle.
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      drive_b(1, 0, i + 4, 0);
      @(negedge clk);
      chk("t4_a_ready", a_ready, 0);
      if (b_ready) nb++;
      cyc();
    end
    chk("t4_b_grants", nb, 4);
    idle();

    // Read granted, reset in the next cycle: response dropped, A wins the tie after.
    drive_a(1, 0, 3, 0);
    @(negedge clk); chk("t5_rd_ready", a_ready, 1);
    cyc();
    idle(); drive_b(1, 0, 2, 0); rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_rsp", a_rsp_valid, 0);
    chk("t5_rst_b_ready", b_ready, 0);
    cyc();
    rst = 1'b0;
    drive_a(1, 0, 1, 0); drive_b(1, 0, 2, 0);
    @(negedge clk);
    chk("t5_post_rsp", a_rsp_valid, 0);
    chk("t5_tie_a", a_ready, 1);
    chk("t5_tie_b", b_ready, 0);
    cyc();
    idle(); cyc();

`ifdef MEMARB_FIXED_PRIO_EN
    // Strict priority: A holds the port while valid.
    drive_a(1, 0, 1, 0); drive_b(1, 0, 2, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fp_a_ready", a_ready, 1);
      chk("fp_b_ready", b_ready, 0);
      cyc();
    end
    drive_a(0, 0, 0, 0);
    @(negedge clk); chk("fp_b_after", b_ready, 1);
    cyc();
    idle();
`endif

    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
